bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial stage for the BPSK transmit path, placed directly downstream of the `div` clock divider. It takes the divider's `div_sig` output, clocked on the same `clk_sig`, and uses its rising edges as bit-rate ticks. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per tick, to the convolutional encoder / modulator. An even-parity bit can be appended per word.

## Interface
- `WIDTH`, default 8: data word width; legal range ≥ 2.
- `clk_sig`  input  1: system clock; all logic on its rising edge.
- `reset_sig`  input  1: reset; asynchronous, active-low.
- `div_sig`  input  1: divided rate signal from `div`, synchronous to `clk_sig`.
- `data_sig`  input  WIDTH: word to serialize.
- `valid_sig`  input  1: `data_sig` valid.
- `ready_sig`  output  1: block can accept a word.
- `bit_sig`  output  1: current serial bit.
- `bit_valid_sig`  output  1: `bit_sig` carries a data or parity bit.
- `busy_sig`  output  1: a word is being serialized.

## Operation
- **Tick:**
  - `div_q` is a register on `div_sig`.
  - `tick = div_sig & ~div_q`, one cycle wide, once per divider period.
  - `div_q` resets to 0, so `div_sig` high on the first cycle after reset counts as a tick.
- **State machine:** IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- **Derived outputs:**
  - `ready_sig = (state == IDLE)`, decoded from the state register.
  - `busy_sig = ~ready_sig`.
- **IDLE:**
  - `valid_sig & ready_sig` loads `shift_reg <= data_sig`, clears `bit_cnt`, and moves to SHIFT.
  - Parity is computed at load: `par <= ^data_sig`.
  - A tick in IDLE drives `bit_sig <= 0` and `bit_valid_sig <= 0`.
- **SHIFT:**
  - Each tick: `bit_sig <= shift_reg[WIDTH-1]`, `bit_valid_sig <= 1`, `shift_reg <= shift_reg << 1`, `bit_cnt <= bit_cnt + 1`.
  - Width of `bit_cnt` is `$clog2(WIDTH+1)`; it never wraps.
  - On the tick where `bit_cnt == WIDTH-1`: go to PARITY if the macro is defined, else IDLE.
  - Inputs are ignored in SHIFT.
- **PARITY:** the next tick drives `bit_sig <= par` and `bit_valid_sig <= 1`, then returns to IDLE.
- **Output hold:** `bit_sig` and `bit_valid_sig` change only on ticks and hold for one full divider period.
- **Continuous streaming:** if the next word is accepted in IDLE before the next tick, that tick outputs the new word's MSB with no gap.
- **Accept and tick in the same IDLE cycle:** the accept wins. The output goes idle for that tick (`bit_valid_sig <= 0`), and the word's MSB appears on the following tick.
- **No ticks:** if `div_sig` is stuck, the state machine waits indefinitely with no timeout.

## Timing
- **Reset values (asynchronous, while `reset_sig == 0`):**
  - state = IDLE, `ready_sig = 1`, `busy_sig = 0`.
  - `bit_sig = 0`, `bit_valid_sig = 0`.
  - `shift_reg = 0`, `bit_cnt = 0`, `par = 0`, `div_q = 0`.
- **Reset mid-word:** the word is discarded; after release the block is in IDLE.
- **Latency:**
  - The accept edge is E. The MSB appears on the edge ending the first tick cycle after E.
  - Word occupancy is WIDTH tick periods, or WIDTH+1 with parity.
- **Ticks and `ready_sig`:**
  - Tick spacing equals the divider NUM, e.g. 4 cycles.
  - `ready_sig` rises on the edge where the last bit (data or parity) is registered.
  - `ready_sig` stays high until the next accept.
- **Handshake:**
  - The transfer happens in the cycle where `valid_sig` and `ready_sig` are both 1.
  - `ready_sig` does not depend combinationally on `valid_sig`.

## Configuration
- Macro: `BIT_SERIALIZER_PARITY_EN`.
- **Defined:** the PARITY state is present, and an even-parity bit (XOR of all WIDTH bits) follows each word's LSB. Each word occupies WIDTH+1 ticks.
- **Undefined:** no PARITY state and no `par` register. Each word occupies WIDTH ticks, and the SHIFT exit goes directly to IDLE.

## Test plan
- **Reset defaults:** assert `reset_sig = 0` mid-word with WIDTH=8 and NUM=4 → outputs immediately show `ready_sig = 1`, `busy_sig = 0`, `bit_sig = 0`, `bit_valid_sig = 0`. The next accepted word serializes from its MSB.
- **Single word, no parity:** `0xA5` with parity off → on successive ticks `bit_sig` is 1,0,1,0,0,1,0,1, each held 4 cycles with `bit_valid_sig = 1`. After the last bit, `ready_sig = 1`. The next tick gives `bit_valid_sig = 0`.
- **Parity:** with `BIT_SERIALIZER_PARITY_EN`, send `0x07` then `0x03`:
  - `0x07` → 8 data bits, then parity 1.
  - `0x03` → 8 data bits, then parity 0.
  - `ready_sig` is low for exactly 9 ticks per word.
- **Back-to-back stream:** drive `valid_sig` constantly high with `0x0F`, `0xF0`, `0x55` → 24 contiguous valid bits with no `bit_valid_sig = 0` gap.
- **Accept coincident with tick:** assert `valid_sig` in IDLE exactly on a tick cycle → that tick outputs `bit_valid_sig = 0`; the MSB appears on the next tick.
- **Tick stall:** hold `div_sig = 0` for 50 cycles mid-word → `bit_sig` and `bit_cnt` are frozen; serialization resumes correctly once ticks resume.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Word/serial-stream bundle for bit_serializer.
// master: upstream word source and downstream bit sink (testbench side).
// slave : the serializer itself.
`timescale 1ns/1ps
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_sig;
    logic             valid_sig;
    logic             ready_sig;
    logic             bit_sig;
    logic             bit_valid_sig;
    logic             busy_sig;

    modport master (
        output data_sig,
        output valid_sig,
        input  ready_sig,
        input  bit_sig,
        input  bit_valid_sig,
        input  busy_sig
    );

    modport slave (
        input  data_sig,
        input  valid_sig,
        output ready_sig,
        output bit_sig,
        output bit_valid_sig,
        output busy_sig
    );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial stage for the BPSK transmit path.
// Accepts WIDTH-bit words over valid/ready and shifts them out MSB-first,
// one bit per rising edge of div_sig (the divider output).
// Optional even-parity bit per word: define BIT_SERIALIZER_PARITY_EN.
`timescale 1ns/1ps
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic              clk_sig,
    input  logic              reset_sig,
    input  logic              div_sig,
    bit_serializer_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic             div_q;
    logic             tick;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             bit_out;
    logic             bit_valid_out;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par;
`endif

    // Rising edge of the divider output is the bit-rate tick.
    assign tick = div_sig & ~div_q;

    // Delay div_sig by one clock for edge detection.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_sig;
        end
    end

    // Serializer FSM with registered serial outputs.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            bit_out       <= 1'b0;
            bit_valid_out <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A tick in IDLE idles the line, even when a word is
                    // accepted in the same cycle; its MSB goes on the next tick.
                    if (tick) begin
                        bit_out       <= 1'b0;
                        bit_valid_out <= 1'b0;
                    end
                    if (bus.valid_sig) begin
                        shift_reg <= bus.data_sig;
                        bit_cnt   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
                        par       <= ^bus.data_sig;
`endif
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        bit_out       <= shift_reg[WIDTH-1];
                        bit_valid_out <= 1'b1;
                        shift_reg     <= shift_reg << 1;
                        bit_cnt       <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_CNT) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                            state <= PARITY;
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        bit_out       <= par;
                        bit_valid_out <= 1'b1;
                        state         <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake status decoded straight from the state register.
    assign bus.ready_sig     = (state == IDLE);
    assign bus.busy_sig      = (state != IDLE);
    assign bus.bit_sig       = bit_out;
    assign bus.bit_valid_sig = bit_valid_out;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer.
// Reference model: a queue of expected serial bits; a word pushes its bits
// (MSB first, plus parity when enabled) when accepted, and each tick pops one.
`timescale 1ns/1ps
module tb_bit_serializer;
    localparam int WIDTH = 8;
    localparam int NUM   = 4;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic clk_sig   = 1'b0;
    logic reset_sig = 1'b1;
    logic div_sig   = 1'b0;

    bit_serializer_if #(.WIDTH(WIDTH)) bus ();

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .div_sig   (div_sig),
        .bus       (bus.slave)
    );

    always #5 clk_sig = ~clk_sig;

    // Model and stimulus state
    logic             exp_q[$];
    logic [WIDTH-1:0] words[$];
    logic             tick_log[$];
    logic             exp_bit   = 1'b0;
    logic             exp_bv    = 1'b0;
    logic             div_prev  = 1'b0;
    int               div_cnt   = 0;
    bit               stall     = 0;
    bit               align     = 0;
    bit               log_en    = 0;
    int               low_ticks = 0;
    int               pass_cnt  = 0;
    int               total     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic cycle();
        logic tick, acc, rdy_exp;
        logic [WIDTH-1:0] w;
        if (stall) begin
            div_sig = 1'b0;
        end else begin
            div_sig = (div_cnt < NUM / 2);
            div_cnt = (div_cnt + 1) % NUM;
        end
        tick    = div_sig && !div_prev;
        rdy_exp = (exp_q.size() == 0);
        if (words.size() > 0 && (!align || tick)) begin
            bus.valid_sig = 1'b1;
            bus.data_sig  = words[0];
        end else begin
            bus.valid_sig = 1'b0;
            bus.data_sig  = WIDTH'($urandom);
        end
        acc = bus.valid_sig && rdy_exp;
        if (tick && (bus.ready_sig == 1'b0)) low_ticks++;
        @(posedge clk_sig);
        #1;
        if (tick) begin
            if (exp_q.size() > 0) begin
                exp_bit = exp_q.pop_front();
                exp_bv  = 1'b1;
            end else begin
                exp_bit = 1'b0;
                exp_bv  = 1'b0;
            end
            if (log_en) tick_log.push_back(bus.bit_valid_sig);
        end
        if (acc) begin
            w = words.pop_front();
            push_word(w);
            if (tick) begin
                check("accept_on_tick_idle", 32'(bus.bit_valid_sig), 32'd0);
                align = 0;
            end
        end
        div_prev = div_sig;
        check("bit_sig",       32'(bus.bit_sig),       32'(exp_bit));
        check("bit_valid_sig", 32'(bus.bit_valid_sig), 32'(exp_bv));
        check("ready_sig",     32'(bus.ready_sig),     32'(exp_q.size() == 0));
        check("busy_sig",      32'(bus.busy_sig),      32'(exp_q.size() != 0));
    endtask

    // Run until all queued words are fully shifted out, with a cycle budget.
    task automatic drain(input int budget);
        int n = 0;
        while ((words.size() + exp_q.size()) != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(words.size() + exp_q.size()), 32'd0);
    endtask

    // Asynchronous reset away from the clock edge; outputs checked at once.
    task automatic do_reset();
        #2;
        reset_sig     = 1'b0;
        div_sig       = 1'b0;
        bus.valid_sig = 1'b0;
        #1;
        check("rst_ready",     32'(bus.ready_sig),     32'd1);
        check("rst_busy",      32'(bus.busy_sig),      32'd0);
        check("rst_bit",       32'(bus.bit_sig),       32'd0);
        check("rst_bit_valid", 32'(bus.bit_valid_sig), 32'd0);
        exp_q.delete();
        words.delete();
        exp_bit  = 1'b0;
        exp_bv   = 1'b0;
        div_prev = 1'b0;
        div_cnt  = 0;
        stall    = 0;
        align    = 0;
        repeat (2) @(posedge clk_sig);
        #2;
        reset_sig = 1'b1;
    endtask

    initial begin
        int run, best;
        logic [WIDTH-1:0] rw;
        bus.valid_sig = 1'b0;
        bus.data_sig  = '0;

        // Power-up reset
        do_reset();
        repeat (6) cycle();

        // Single word 0xA5, then idle ticks
        words.push_back(8'hA5);
        drain(200);
        repeat (8) cycle();

        // Parity pair: ready low for NB ticks per word
        low_ticks = 0;
        words.push_back(8'h07);
        drain(200);
        check("ready_low_ticks_07", 32'(low_ticks), 32'(NB));
        repeat (3) cycle();
        low_ticks = 0;
        words.push_back(8'h03);
        drain(200);
        check("ready_low_ticks_03", 32'(low_ticks), 32'(NB));
        repeat (6) cycle();

        // Back-to-back stream with valid held high
        tick_log.delete();
        log_en = 1;
        words.push_back(8'h0F);
        words.push_back(8'hF0);
        words.push_back(8'h55);
        drain(400);
        log_en = 0;
        run  = 0;
        best = 0;
        foreach (tick_log[i]) begin
            if (tick_log[i]) run++; else run = 0;
            if (run > best) best = run;
        end
        check("stream_contiguous_bits", 32'(best), 32'(3 * NB));
        repeat (6) cycle();

        // Accept coincident with a tick
        align = 1;
        words.push_back(8'hC3);
        drain(200);
        check("align_consumed", 32'(align), 32'd0);
        repeat (6) cycle();

        // Tick stall mid-word
        words.push_back(8'h96);
        repeat (14) cycle();
        stall = 1;
        repeat (50) cycle();
        stall = 0;
        drain(200);
        repeat (6) cycle();

        // Reset mid-word, then a fresh word from its MSB
        words.push_back(8'h3C);
        repeat (13) cycle();
        do_reset();
        words.push_back(8'hE1);
        drain(200);
        repeat (6) cycle();

        // Randomized words, gaps and short stalls
        for (int k = 0; k < 30; k++) begin
            rw = WIDTH'($urandom);
            words.push_back(rw);
            if ($urandom_range(0, 7) == 0) begin
                stall = 1;
                repeat ($urandom_range(1, 12)) cycle();
                stall = 0;
            end
            repeat ($urandom_range(0, 40)) cycle();
        end
        drain(4000);
        repeat (8) cycle();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
